// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and constants for the branch resolve unit
package bpu_pkg;

  localparam int XLEN           = 32;
  localparam int PREDITOR_DEPTH = 64;
  localparam int IDXW           = $clog2(PREDITOR_DEPTH);
  localparam int QUEUE_DEPTH    = 8;

  localparam logic [XLEN-1:0] INST_LEN_16 = XLEN'(2);
  localparam logic [XLEN-1:0] INST_LEN_32 = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [IDXW-1:0] pred_index;
  } bpu_entry_t;

  // Sequential successor of a branch; wraps naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] fall_through(input logic [XLEN-1:0] pc, input logic len16);
    return pc + (len16 ? INST_LEN_16 : INST_LEN_32);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - allocation and resolution handshakes between pipeline and branch queue
interface branch_resolve_unit_if;
  import bpu_pkg::*;

  logic            alloc_valid;
  logic            alloc_ready;
  logic [XLEN-1:0] alloc_pc;
  logic            alloc_pred_taken;
  logic [XLEN-1:0] alloc_pred_target;
  logic [IDXW-1:0] alloc_pred_index;

  logic            res_valid;
  logic            res_ready;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_cond;
  logic            res_len16;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_pred_index,
    output res_valid, res_taken, res_target, res_cond, res_len16,
    input  alloc_ready, res_ready
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target, alloc_pred_index,
    input  res_valid, res_taken, res_target, res_cond, res_len16,
    output alloc_ready, res_ready
  );

endinterface

// File: rtl/branch_queue.sv
// rtl/branch_queue.sv - in-order circular queue of predicted branches awaiting resolution
module branch_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       alloc,
  input  bpu_entry_t alloc_entry,
  input  logic       pop,
  input  logic       clear_to_head,
  input  logic       clear_all,
  output bpu_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  bpu_entry_t  mem [DEPTH];
  logic        write_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign write_en = alloc && !full && !clear_all && !clear_to_head;

  // clear_to_head leaves only the current head, so together with pop the queue ends empty.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_all) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (clear_to_head)
        wr_ptr <= rd_ptr + PTR_ONE;
      else if (write_en)
        wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (write_en)
      mem[wr_ptr[AW-1:0]] <= alloc_entry;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves queued branch predictions, redirects on mispredict, feeds predictor updates
module branch_resolve_unit
  import bpu_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  branch_resolve_unit_if.slave  bru,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  preditorUpdate,
  output logic                  branchResult,
  output logic [IDXW-1:0]       lastIndex,
  output logic                  btbUpdate,
  output logic                  branchType,
  output logic [XLEN-1:0]       target,
  output logic [XLEN-1:0]       branchAddr,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  bpu_entry_t head;
  bpu_entry_t alloc_entry;
  logic       q_full;
  logic       q_empty;
  logic       res_fire;
  logic       alloc_fire;
  logic       target_miss;
  logic       mispredict;
  logic       btb_write;
  logic       squash;

  assign bru.alloc_ready = !q_full;
  assign bru.res_ready   = !q_empty;

  assign res_fire   = bru.res_valid && !q_empty && !flush;
  assign alloc_fire = bru.alloc_valid && !q_full && !flush;

  assign target_miss = (head.pred_target != bru.res_target);
  assign mispredict  = (head.pred_taken != bru.res_taken) || (bru.res_taken && target_miss);
  assign btb_write   = bru.res_taken && (!head.pred_taken || target_miss);
  // A mispredict kills everything younger, including a branch arriving this cycle.
  assign squash      = res_fire && mispredict;

  assign alloc_entry = '{pc:          bru.alloc_pc,
                         pred_taken:  bru.alloc_pred_taken,
                         pred_target: bru.alloc_pred_target,
                         pred_index:  bru.alloc_pred_index};

  branch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock         (clock),
    .resetn        (resetn),
    .alloc         (alloc_fire && !squash),
    .alloc_entry   (alloc_entry),
    .pop           (res_fire),
    .clear_to_head (squash),
    .clear_all     (flush),
    .head          (head),
    .full          (q_full),
    .empty         (q_empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      preditorUpdate   <= 1'b0;
      branchResult     <= 1'b0;
      lastIndex        <= '0;
      btbUpdate        <= 1'b0;
      branchType       <= 1'b0;
      target           <= '0;
      branchAddr       <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= squash;
      preditorUpdate <= res_fire && bru.res_cond;
      btbUpdate      <= res_fire && btb_write;
      if (squash) begin
        redirect_pc      <= bru.res_taken ? bru.res_target : fall_through(head.pc, bru.res_len16);
        mispredict_count <= mispredict_count + 32'd1;
      end
      if (res_fire) begin
        branchResult <= bru.res_taken;
        lastIndex    <= head.pred_index;
        branchType   <= !bru.res_cond;
        target       <= bru.res_target;
        branchAddr   <= head.pc;
        branch_count <= branch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  import bpu_pkg::*;

  logic            clock = 1'b0;
  logic            resetn = 1'b1;
  logic            flush = 1'b0;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            preditorUpdate;
  logic            branchResult;
  logic [IDXW-1:0] lastIndex;
  logic            btbUpdate;
  logic            branchType;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] branchAddr;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  branch_resolve_unit_if bru();

  branch_resolve_unit dut (
    .clock            (clock),
    .resetn           (resetn),
    .flush            (flush),
    .bru              (bru),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .preditorUpdate   (preditorUpdate),
    .branchResult     (branchResult),
    .lastIndex        (lastIndex),
    .btbUpdate        (btbUpdate),
    .branchType       (branchType),
    .target           (target),
    .branchAddr       (branchAddr),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            pt;
    logic [XLEN-1:0] tgt;
    logic [IDXW-1:0] idx;
  } ment_t;

  typedef struct {
    logic            rv;
    logic [XLEN-1:0] rpc;
    logic            pu;
    logic            br;
    logic [IDXW-1:0] li;
    logic            bu;
    logic            bt;
    logic [XLEN-1:0] tg;
    logic [XLEN-1:0] ba;
    logic [31:0]     bc;
    logic [31:0]     mc;
  } exp_t;

  ment_t mq[$];
  exp_t  sb[$];
  exp_t  cur;
  exp_t  e;
  int    checks = 0;
  int    failures = 0;

  task automatic reset_model();
    mq.delete();
    sb.delete();
    cur = '{default: '0};
  endtask

  // Drives one cycle; the reference queue decides what the DUT must report at the next edge.
  task automatic drive(input logic av, input logic [XLEN-1:0] apc, input logic apt,
                       input logic [XLEN-1:0] atgt, input logic [IDXW-1:0] aidx,
                       input logic rv, input logic rt, input logic [XLEN-1:0] rtgt,
                       input logic rc, input logic rl, input logic fl);
    ment_t h;
    ment_t n;
    logic  a_ok;
    logic  r_ok;
    logic  mis;
    bru.alloc_valid       = av;
    bru.alloc_pc          = apc;
    bru.alloc_pred_taken  = apt;
    bru.alloc_pred_target = atgt;
    bru.alloc_pred_index  = aidx;
    bru.res_valid         = rv;
    bru.res_taken         = rt;
    bru.res_target        = rtgt;
    bru.res_cond          = rc;
    bru.res_len16         = rl;
    flush                 = fl;
    a_ok = av && (mq.size() < QUEUE_DEPTH) && !fl;
    r_ok = rv && (mq.size() > 0) && !fl;
    mis  = 1'b0;
    if (r_ok) begin
      h = mq.pop_front();
      mis = (h.pt != rt) || (rt && (h.tgt != rtgt));
      cur.rv = mis;
      cur.pu = rc;
      cur.br = rt;
      cur.li = h.idx;
      cur.bu = rt && (!h.pt || (h.tgt != rtgt));
      cur.bt = !rc;
      cur.tg = rtgt;
      cur.ba = h.pc;
      cur.bc = cur.bc + 32'd1;
      if (mis) begin
        cur.rpc = rt ? rtgt : (h.pc + (rl ? 32'd2 : 32'd4));
        cur.mc  = cur.mc + 32'd1;
        mq.delete();
      end
      sb.push_back(cur);
    end
    if (a_ok && !mis) begin
      n.pc = apc; n.pt = apt; n.tgt = atgt; n.idx = aidx;
      mq.push_back(n);
    end
    if (fl) mq.delete();
    @(posedge clock);
    #1;
    bru.alloc_valid = 1'b0;
    bru.res_valid   = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic alloc(input logic [XLEN-1:0] pc, input logic pt, input logic [XLEN-1:0] tgt, input logic [IDXW-1:0] idx);
    drive(1'b1, pc, pt, tgt, idx, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input logic [XLEN-1:0] rtgt, input logic rc, input logic rl);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1, rt, rtgt, rc, rl, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [4:0]  ctl;
    logic [IDXW+127:0] dat;
    bru.alloc_valid = 1'b0;
    bru.res_valid   = 1'b0;
    #2 resetn = 1'b0;
    #2;
    ctl = {bru.alloc_ready, bru.res_ready, redirect_valid, preditorUpdate, btbUpdate};
    checks++;
    if (ctl !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=%b", ctl, 5'b10000);
    end
    dat = {redirect_pc, lastIndex, target, branchAddr, branch_count | mispredict_count};
    checks++;
    if (dat !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", dat);
    end
    checks++;
    if ({branchResult, branchType} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00", {branchResult, branchType});
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    reset_model();
  endtask

  task automatic test_basic();
    alloc(32'h100, 1'b1, 32'h200, 6'd5);
    resolve(1'b1, 32'h200, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({preditorUpdate, branchResult, btbUpdate, redirect_valid} !== {e.pu, e.br, e.bu, e.rv}) begin
      failures++;
      $display("FAIL basic_pulses got=%b want=%b", {preditorUpdate, branchResult, btbUpdate, redirect_valid}, {e.pu, e.br, e.bu, e.rv});
    end
    checks++;
    if (lastIndex !== 6'd5 || lastIndex !== e.li) begin
      failures++;
      $display("FAIL basic_index got=%0d want=%0d", lastIndex, e.li);
    end
    checks++;
    if (branch_count !== e.bc) begin
      failures++;
      $display("FAIL basic_count got=%0d want=%0d", branch_count, e.bc);
    end
    idle();
    checks++;
    if (preditorUpdate !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse_width got=%b want=0", preditorUpdate);
    end
  endtask

  task automatic test_mispredict_len16();
    alloc(32'h100, 1'b1, 32'h200, 6'd1);
    resolve(1'b0, 32'h0, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc} || redirect_pc !== 32'h102) begin
      failures++;
      $display("FAIL len16_redirect got=%b/%h want=%b/%h", redirect_valid, redirect_pc, e.rv, e.rpc);
    end
    checks++;
    if (mispredict_count !== e.mc || bru.res_ready !== 1'b0) begin
      failures++;
      $display("FAIL len16_count got=%0d/%b want=%0d/0", mispredict_count, bru.res_ready, e.mc);
    end
    idle();
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL len16_pulse_width got=%b want=0", redirect_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < QUEUE_DEPTH; i++)
      alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h2000, IDXW'(i));
    checks++;
    if ({bru.alloc_ready, bru.res_ready} !== 2'b01) begin
      failures++;
      $display("FAIL full_ready got=%b want=01", {bru.alloc_ready, bru.res_ready});
    end
    drive(1'b1, 32'h3000, 1'b0, 32'h0, 6'd15, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (lastIndex !== e.li || bru.alloc_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop got=%0d/%b want=%0d/1", lastIndex, bru.alloc_ready, e.li);
    end
    for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
      resolve(1'b0, 32'h0, 1'b1, 1'b0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL full_drain_model empty at %0d", i);
      end else begin
        e = sb.pop_front();
        checks++;
        if (lastIndex !== e.li) begin
          failures++;
          $display("FAIL full_drain_%0d got=%0d want=%0d", i, lastIndex, e.li);
        end
      end
    end
    checks++;
    if (bru.res_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refused_alloc got res_ready=%b want=0", bru.res_ready);
    end
  endtask

  task automatic test_mispredict_discard();
    alloc(32'h400, 1'b0, 32'h0, 6'd1);
    alloc(32'h404, 1'b0, 32'h0, 6'd2);
    alloc(32'h408, 1'b0, 32'h0, 6'd3);
    drive(1'b1, 32'h500, 1'b1, 32'h600, 6'd7, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({redirect_valid, redirect_pc, btbUpdate} !== {e.rv, e.rpc, e.bu}) begin
      failures++;
      $display("FAIL discard_redirect got=%b/%h/%b want=%b/%h/%b", redirect_valid, redirect_pc, btbUpdate, e.rv, e.rpc, e.bu);
    end
    idle();
    checks++;
    if ({bru.alloc_ready, bru.res_ready} !== 2'b10) begin
      failures++;
      $display("FAIL discard_empty got=%b want=10", {bru.alloc_ready, bru.res_ready});
    end
  endtask

  task automatic test_jump_wrap();
    alloc(32'hFFFF_FFFC, 1'b0, 32'h0, 6'd9);
    resolve(1'b1, 32'h40, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({btbUpdate, branchType, preditorUpdate, redirect_valid} !== {e.bu, e.bt, e.pu, e.rv} ||
        {btbUpdate, branchType, preditorUpdate} !== 3'b110) begin
      failures++;
      $display("FAIL jump_flags got=%b want=%b", {btbUpdate, branchType, preditorUpdate, redirect_valid}, {e.bu, e.bt, e.pu, e.rv});
    end
    checks++;
    if ({branchAddr, redirect_pc, target} !== {32'hFFFF_FFFC, 32'h40, 32'h40}) begin
      failures++;
      $display("FAIL jump_addr got=%h/%h/%h want=fffffffc/40/40", branchAddr, redirect_pc, target);
    end
    alloc(32'hFFFF_FFFC, 1'b1, 32'h80, 6'd3);
    resolve(1'b0, 32'h0, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin
      failures++;
      $display("FAIL wrap_fallthrough got=%b/%h want=%b/%h", redirect_valid, redirect_pc, e.rv, e.rpc);
    end
  endtask

  task automatic test_flush();
    alloc(32'h700, 1'b0, 32'h0, 6'd4);
    alloc(32'h704, 1'b0, 32'h0, 6'd5);
    drive(1'b1, 32'h708, 1'b0, 32'h0, 6'd6, 1'b1, 1'b1, 32'h999, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({redirect_valid, preditorUpdate, btbUpdate, bru.res_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL flush_pulses got=%b want=0000", {redirect_valid, preditorUpdate, btbUpdate, bru.res_ready});
    end
    checks++;
    if ({branch_count, mispredict_count} !== {cur.bc, cur.mc}) begin
      failures++;
      $display("FAIL flush_counts got=%0d/%0d want=%0d/%0d", branch_count, mispredict_count, cur.bc, cur.mc);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] tgts [4];
    logic [IDXW+73:0] obs;
    logic [IDXW+73:0] want;
    tgts[0] = 32'h40; tgts[1] = 32'h80; tgts[2] = 32'hC0; tgts[3] = 32'h100;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if ({bru.alloc_ready, bru.res_ready} !== {mq.size() < QUEUE_DEPTH, mq.size() > 0}) begin
        failures++;
        $display("FAIL b2b_ready_%0d got=%b want=%b", i, {bru.alloc_ready, bru.res_ready}, {mq.size() < QUEUE_DEPTH, mq.size() > 0});
      end
      drive(1'($urandom_range(0, 2) != 0), 32'($urandom_range(0, 1023) * 2), 1'($urandom_range(0, 1)),
            tgts[$urandom_range(0, 3)], IDXW'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgts[$urandom_range(0, 3)],
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        obs  = {redirect_valid, preditorUpdate, branchResult, lastIndex, btbUpdate, branchType, target, branchAddr};
        want = {e.rv, e.pu, e.br, e.li, e.bu, e.bt, e.tg, e.ba};
        checks++;
        if (obs !== want || (e.rv && redirect_pc !== e.rpc)) begin
          failures++;
          $display("FAIL b2b_update_%0d got=%h/%h want=%h/%h", i, obs, redirect_pc, want, e.rpc);
        end
      end else begin
        checks++;
        if ({redirect_valid, preditorUpdate, btbUpdate} !== 3'b000) begin
          failures++;
          $display("FAIL b2b_idle_%0d got=%b want=000", i, {redirect_valid, preditorUpdate, btbUpdate});
        end
      end
      checks++;
      if ({branch_count, mispredict_count} !== {cur.bc, cur.mc}) begin
        failures++;
        $display("FAIL b2b_counts_%0d got=%0d/%0d want=%0d/%0d", i, branch_count, mispredict_count, cur.bc, cur.mc);
      end
    end
  endtask

  task automatic test_reset_mid();
    alloc(32'h800, 1'b1, 32'h900, 6'd1);
    alloc(32'h804, 1'b1, 32'h900, 6'd2);
    resolve(1'b0, 32'h0, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    checks++;
    if ({bru.alloc_ready, bru.res_ready, redirect_valid, preditorUpdate} !== 4'b1000 ||
        {branch_count, mispredict_count, redirect_pc} !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%b/%0d/%0d/%h want=1000/0/0/0",
               {bru.alloc_ready, bru.res_ready, redirect_valid, preditorUpdate}, branch_count, mispredict_count, redirect_pc);
    end
    #2 resetn = 1'b1;
    reset_model();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bru.alloc_valid = 1'b0; bru.alloc_pc = '0; bru.alloc_pred_taken = 1'b0;
    bru.alloc_pred_target = '0; bru.alloc_pred_index = '0;
    bru.res_valid = 1'b0; bru.res_taken = 1'b0; bru.res_target = '0;
    bru.res_cond = 1'b0; bru.res_len16 = 1'b0;
    reset_model();
    test_reset();
    test_basic();
    test_mispredict_len16();
    test_full();
    test_mispredict_discard();
    test_jump_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
